// File: rtl/gowin_user_flash_ctrl_if.sv
// Command/response bus between fabric logic (loaders, UART bridges) and the
// user-flash command controller.
interface gowin_user_flash_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high. cmd_op/cmd_addr/cmd_wdata/wr_lock are only looked
  // at on that edge and are ignored while cmd_ready is low. rsp_valid is a
  // one-cycle pulse with no ready; the requester must take it when it appears.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              wr_lock;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, wr_lock,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, wr_lock,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/gowin_user_flash_ctrl.sv
// Command-level controller for the on-chip user flash: turns read / program /
// page-erase commands into timed address setup, strobe pulse and recovery.
module gowin_user_flash_ctrl #(
  parameter int ROW_W     = 6,
  parameter int COL_W     = 6,
  parameter int DATA_W    = 32,
  parameter int SETUP_CYC = 1,
  parameter int RD_CYC    = 2,
  parameter int PROG_CYC  = 16,
  parameter int ERASE_CYC = 64
) (
  input  logic                  aclk,
  input  logic                  resetn,
  gowin_user_flash_ctrl_if.slave bus,
  output logic                  busy,
  output logic [ROW_W-1:0]      f_ra,
  output logic [COL_W-1:0]      f_ca,
  output logic [DATA_W-1:0]     f_din,
  input  logic [DATA_W-1:0]     f_dout,
  output logic                  f_oe,
  output logic                  f_pw,
  output logic                  f_pe,
  output logic [2:0]            state_dbg
);

  localparam int MAX_AB  = (SETUP_CYC > RD_CYC) ? SETUP_CYC : RD_CYC;
  localparam int MAX_CD  = (PROG_CYC > ERASE_CYC) ? PROG_CYC : ERASE_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter is loaded with (length - 1) so the phase ends on the cycle it reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] PROG_LD  = CNT_W'(PROG_CYC - 1);
  localparam logic [CNT_W-1:0] ERASE_LD = CNT_W'(ERASE_CYC - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_PROG  = 3'd3,
    S_ERASE = 3'd4,
    S_RECOV = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept;
  logic              cmd_bad;

  assign accept  = bus.cmd_valid && cmd_ready_q;
  // Reserved op, or a write-type op while the lock is held, is answered without touching the array.
  assign cmd_bad = (bus.cmd_op == OP_RSVD) || ((bus.cmd_op != OP_READ) && bus.wr_lock);

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= OP_READ;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      f_ra        <= '0;
      f_ca        <= '0;
      f_din       <= '0;
      f_oe        <= 1'b0;
      f_pw        <= 1'b0;
      f_pe        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            op_q        <= bus.cmd_op;
            f_ra        <= bus.cmd_addr[ROW_W+COL_W-1:COL_W];
            f_ca        <= (bus.cmd_op == OP_ERASE) ? '0 : bus.cmd_addr[COL_W-1:0];
            f_din       <= bus.cmd_wdata;
            rsp_err_q   <= cmd_bad;
            if (cmd_bad) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              cnt         <= '0;
            end else begin
              state <= S_SETUP;
              cnt   <= SETUP_LD;
            end
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            case (op_q)
              OP_READ: begin
                state <= S_READ;
                f_oe  <= 1'b1;
                cnt   <= RD_LD;
              end
              OP_PROG: begin
                state <= S_PROG;
                f_pw  <= 1'b1;
                cnt   <= PROG_LD;
              end
              default: begin
                state <= S_ERASE;
                f_pe  <= 1'b1;
                cnt   <= ERASE_LD;
              end
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_READ: begin
          if (cnt == '0) begin
            // Last strobe cycle: the array output is settled, capture it as the strobe drops.
            f_oe        <= 1'b0;
            rsp_rdata_q <= f_dout;
            state       <= S_RECOV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PROG: begin
          if (cnt == '0) begin
            f_pw  <= 1'b0;
            state <= S_RECOV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ERASE: begin
          if (cnt == '0) begin
            f_pe  <= 1'b0;
            state <= S_RECOV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RECOV: begin
          state       <= S_RESP;
          rsp_valid_q <= 1'b1;
          cnt         <= '0;
        end
        S_RESP: begin
          state       <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
